// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator;
// one bit is resolved per cycle, so an operation takes WIDTH+1 edges.
// Optional macro MULDIV_SIGNED_EN enables signed MULT/DIV (op_i[1]=1).
// Ports:
//   clk_i, rst_i        clock, async active-high reset
//   start_i, op_i       request and op (00 MULTU, 01 DIVU, 10 MULT, 11 DIV)
//   a_i, b_i            operands, sampled on the accept edge
//   flush_i             abort any in-flight operation
//   mthi_i, mtlo_i      write wdata_i to HI / LO when not busy
//   busy_o, done_o      running / one-cycle result-written pulse
//   hi_o, lo_o          HI (product high / remainder), LO (low / quotient)
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_div;

    logic               w_idle_or_done;
    logic               w_accept;
    logic               w_dbz;
    logic               w_last;
    logic               w_fin;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_msum;
    logic [WIDTH:0]     w_rsh;
    logic [WIDTH:0]     w_dsub;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_mnext;
    logic [2*WIDTH-1:0] w_dnext;
    logic [2*WIDTH-1:0] w_step;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_idle_or_done = (r_state != RUN);
    assign w_accept       = w_idle_or_done & start_i & ~flush_i;
    assign w_dbz          = w_accept & op_i[0] & (b_i == '0);
    assign w_last         = (r_state == RUN) & (r_cnt == CNT_W'(WIDTH - 1));
    assign w_fin          = w_last & ~flush_i;

`ifdef MULDIV_SIGNED_EN
    logic w_sa;
    logic w_sb;
    logic r_neg_q;
    logic r_neg_r;
    logic [2*WIDTH-1:0] w_prod;

    assign w_sa    = op_i[1] & a_i[WIDTH-1];
    assign w_sb    = op_i[1] & b_i[WIDTH-1];
    assign w_a_mag = w_sa ? -a_i : a_i;
    assign w_b_mag = w_sb ? -b_i : b_i;
`else
    assign w_a_mag = a_i;
    assign w_b_mag = b_i;
`endif

    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (LSB of shifting r_a) is set, then shift right.
    assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                   + {1'b0, (r_a[0] ? r_b : '0)};
    assign w_mnext = {w_msum, r_acc[WIDTH-1:1]};

    // Divide: bring in the next dividend bit (MSB of shifting r_a),
    // subtract the divisor if it fits; quotient bits enter at the LSB.
    assign w_rsh   = {r_acc[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_qbit  = (w_rsh >= {1'b0, r_b});
    assign w_dsub  = w_rsh - {1'b0, r_b};
    assign w_dnext = {(w_qbit ? w_dsub[WIDTH-1:0] : w_rsh[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_qbit};

    assign w_step  = r_div ? w_dnext : w_mnext;

`ifdef MULDIV_SIGNED_EN
    assign w_prod = r_neg_q ? -w_step : w_step;
    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            w_res_hi = r_neg_r ? -w_step[2*WIDTH-1:WIDTH]
                               : w_step[2*WIDTH-1:WIDTH];
            w_res_lo = r_neg_q ? -w_step[WIDTH-1:0]
                               : w_step[WIDTH-1:0];
        end
    end
`else
    assign w_res_hi = w_step[2*WIDTH-1:WIDTH];
    assign w_res_lo = w_step[WIDTH-1:0];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE, DONE: begin
                if (w_dbz) begin
                    w_state_nxt = DONE;
                end else if (w_accept) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_cnt <= '0;
            r_div <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
`ifdef MULDIV_SIGNED_EN
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a   <= w_a_mag;
                r_b   <= w_b_mag;
                r_div <= op_i[0];
                r_acc <= '0;
                r_cnt <= '0;
`ifdef MULDIV_SIGNED_EN
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
`endif
            end else if (r_state == RUN) begin
                r_acc <= w_step;
                r_a   <= r_div ? {r_a[WIDTH-2:0], 1'b0}
                               : {1'b0, r_a[WIDTH-1:1]};
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Result writes win over mthi/mtlo on the same edge.
            if (w_dbz) begin
                r_hi <= a_i;
                r_lo <= '1;
            end else if (w_fin) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_idle_or_done) begin
                if (mthi_i) begin
                    r_hi <= wdata_i;
                end
                if (mtlo_i) begin
                    r_lo <= wdata_i;
                end
            end
        end
    end

    assign busy_o = (r_state == RUN);
    assign done_o = (r_state == DONE);
    assign hi_o   = r_hi;
    assign lo_o   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, corner sequences and random ops
// against an arithmetic reference model of muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         mthi = 1'b0;
    logic         mtlo = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string        nm;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eh;
        logic [W-1:0] el;
    } vec_t;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .op_i    (op),
        .a_i     (a),
        .b_i     (b),
        .flush_i (flush),
        .mthi_i  (mthi),
        .mtlo_i  (mtlo),
        .wdata_i (wdata),
        .busy_o  (busy),
        .done_o  (done),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on 64-bit values.
    function automatic void ref_op(input logic [1:0] o,
                                   input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   output logic [W-1:0] rh,
                                   output logic [W-1:0] rl);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        bit          sgn;
`ifdef MULDIV_SIGNED_EN
        sgn = o[1];
`else
        sgn = 1'b0;
`endif
        sx = $signed(x);
        sy = $signed(y);
        if (o[0] && y == '0) begin
            rh = x;
            rl = '1;
        end else if (!o[0]) begin
            if (sgn) p = sx * sy;
            else     p = {32'b0, x} * {32'b0, y};
            rh = p[63:32];
            rl = p[31:0];
        end else if (sgn) begin
            q  = sx / sy;
            r  = sx % sy;
            rh = r[31:0];
            rl = q[31:0];
        end else begin
            rh = x % y;
            rl = x / y;
        end
    endfunction

    // Called just after an edge; waits (bounded) for done_o.
    task automatic wait_done(input logic [W-1:0] ph, input logic [W-1:0] pl,
                             output int edges, output int busyc,
                             output bit stable);
        edges  = 0;
        busyc  = 0;
        stable = 1'b1;
        while (!done && edges < 100) begin
            if (busy) busyc++;
            if (hi !== ph || lo !== pl) stable = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic do_op(input string nm, input logic [1:0] o,
                         input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
        int           edges;
        int           busyc;
        bit           stable;
        bit           dbz;
        logic [W-1:0] ph;
        logic [W-1:0] pl;
        ph  = hi;
        pl  = lo;
        dbz = o[0] && (y == '0);
        start = 1'b1;
        op = o;
        a  = x;
        b  = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 2'($urandom);
        a  = $urandom;
        b  = $urandom;
        wait_done(ph, pl, edges, busyc, stable);
        check({nm, ".latency"}, 64'(edges), dbz ? 64'd0 : 64'(W));
        check({nm, ".busy_cycles"}, 64'(busyc), dbz ? 64'd0 : 64'(W));
        if (!dbz) check({nm, ".hilo_stable"}, 64'(stable), 64'd1);
        check({nm, ".hi"}, 64'(hi), 64'(eh));
        check({nm, ".lo"}, 64'(lo), 64'(el));
        @(posedge clk);
        #1;
        check({nm, ".done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        vec_t         tbl[11];
        int           edges;
        int           busyc;
        int           seen;
        bit           stable;
        logic [1:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;
        logic [W-1:0] rh;
        logic [W-1:0] rl;

        tbl[0]  = '{"multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001};
        tbl[1]  = '{"divu_100_7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14};
        tbl[2]  = '{"divu_by0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
        tbl[3]  = '{"multu_zero", 2'b00, 32'd0, 32'h12345678, 32'd0, 32'd0};
        tbl[4]  = '{"divu_by1", 2'b01, 32'hFFFFFFFF, 32'd1,
                    32'd0, 32'hFFFFFFFF};
        tbl[5]  = '{"div_by0", 2'b11, 32'hFFFFFFF9, 32'd0,
                    32'hFFFFFFF9, 32'hFFFFFFFF};
`ifdef MULDIV_SIGNED_EN
        tbl[6]  = '{"div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[7]  = '{"mult_m3_5", 2'b10, 32'hFFFFFFFD, 32'd5,
                    32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[8]  = '{"div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF,
                    32'd0, 32'h80000000};
        tbl[9]  = '{"div_7_m2", 2'b11, 32'd7, 32'hFFFFFFFE,
                    32'd1, 32'hFFFFFFFD};
`else
        tbl[6]  = '{"div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2,
                    32'd1, 32'h7FFFFFFC};
        tbl[7]  = '{"mult_m3_5", 2'b10, 32'hFFFFFFFD, 32'd5,
                    32'd4, 32'hFFFFFFF1};
        tbl[8]  = '{"div_min_m1", 2'b11, 32'h80000000, 32'hFFFFFFFF,
                    32'h80000000, 32'd0};
        tbl[9]  = '{"div_7_m2", 2'b11, 32'd7, 32'hFFFFFFFE,
                    32'd7, 32'd0};
`endif
        tbl[10] = '{"multu_3_4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12};

        // Reset state
        #12;
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            do_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].eh, tbl[i].el);
        end

        // Preload HI/LO, then flush a multiply on RUN cycle 10
        mthi = 1'b1;
        wdata = 32'h11;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b1;
        wdata = 32'h22;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check("mthi.hi", 64'(hi), 64'h11);
        check("mtlo.lo", 64'(lo), 64'h22);
        start = 1'b1;
        op = 2'b00;
        a = 32'd3;
        b = 32'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush.busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush.busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(posedge clk);
            #1;
        end
        check("flush.no_done", 64'(seen), 64'd0);
        check("flush.hi", 64'(hi), 64'h11);
        check("flush.lo", 64'(lo), 64'h22);

        // flush_i beats start_i in the same cycle
        start = 1'b1;
        flush = 1'b1;
        op = 2'b01;
        a = 32'd9;
        b = 32'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_prio.busy", 64'(busy), 64'd0);
        check("flush_prio.done", 64'(done), 64'd0);
        check("flush_prio.hi", 64'(hi), 64'h11);

        // mtlo during RUN is ignored
        start = 1'b1;
        op = 2'b01;
        a = 32'd100;
        b = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        mtlo = 1'b1;
        wdata = 32'hAB;
        @(posedge clk);
        #1;
        mtlo = 1'b0;
        check("mtlo_run.lo_now", 64'(lo), 64'h22);
        wait_done(32'h11, 32'h22, edges, busyc, stable);
        check("mtlo_run.latency", 64'(edges + 5), 64'(W));
        check("mtlo_run.stable", 64'(stable), 64'd1);
        check("mtlo_run.lo", 64'(lo), 64'd14);
        check("mtlo_run.hi", 64'(hi), 64'd2);

        // Back-to-back start in DONE, with mthi on the accept edge
        start = 1'b1;
        op = 2'b00;
        a = 32'd3;
        b = 32'd4;
        mthi = 1'b1;
        wdata = 32'h55;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi = 1'b0;
        check("b2b.busy", 64'(busy), 64'd1);
        check("b2b.mthi_hi", 64'(hi), 64'h55);
        wait_done(32'h55, 32'd14, edges, busyc, stable);
        check("b2b.latency", 64'(edges), 64'(W));
        check("b2b.hi", 64'(hi), 64'd0);
        check("b2b.lo", 64'(lo), 64'd12);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-RUN
        start = 1'b1;
        op = 2'b00;
        a = 32'hFFFFFFFF;
        b = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst.busy", 64'(busy), 64'd0);
        check("arst.done", 64'(done), 64'd0);
        check("arst.hi", 64'(hi), 64'd0);
        check("arst.lo", 64'(lo), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_op("after_rst", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42);

        // Random operations against the model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            if ($urandom_range(0, 7) == 0)      ry = '0;
            else if ($urandom_range(0, 2) == 0) ry = $urandom_range(1, 20);
            else                                ry = $urandom;
            if ($urandom_range(0, 3) == 0) rx = $urandom_range(0, 300);
            ref_op(ro, rx, ry, rh, rl);
            do_op("rand", ro, rx, ry, rh, rl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
